// File: rtl/hpi_resp_pkg.sv
// hpi_resp_pkg: shared register selects, FSM states and status bit positions for hpi_responder
package hpi_resp_pkg;
  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;
  localparam int ST_MBX_IN  = 0;
  localparam int ST_MBX_OUT = 1;
  localparam int ST_ERR     = 15;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DRV,
    S_WR,
    S_WAIT_REL
  } hpi_state_e;
endpackage

// File: rtl/hpi_resp_mem.sv
// hpi_resp_mem: single-port 16-bit synchronous RAM with one-cycle read latency
module hpi_resp_mem #(
  parameter int MEM_WORDS = 4096,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [MEM_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/hpi_responder.sv
// hpi_responder: HPI device-side emulator (memory via pointer, mailbox, status); HPI_RESP_SYNC_EN adds 2-flop input sync
module hpi_responder
  import hpi_resp_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int AW = 12
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  hpi_addr_i,
  input  logic        hpi_cs_n_i,
  input  logic        hpi_r_n_i,
  input  logic        hpi_w_n_i,
  input  logic        hpi_rst_n_i,
  input  logic [15:0] hpi_data_i,
  output logic [15:0] hpi_data_o,
  output logic        hpi_data_oe,
  output logic        hpi_int,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr
);
  localparam logic [21:0] CAP_IDLE = {2'b00, 4'b1111, 16'h0000};
  logic [21:0] raw, cap;
  logic [1:0]  c_addr;
  logic        c_cs_n, c_r_n, c_w_n, c_rst_n;
  logic [15:0] c_data;
  assign raw = {hpi_addr_i, hpi_cs_n_i, hpi_r_n_i, hpi_w_n_i, hpi_rst_n_i, hpi_data_i};
`ifdef HPI_RESP_SYNC_EN
  logic [21:0] meta;
  always_ff @(posedge clk_clk) begin
    meta <= reset_reset ? CAP_IDLE : raw;
    cap  <= reset_reset ? CAP_IDLE : meta;
  end
`else
  always_ff @(posedge clk_clk) cap <= reset_reset ? CAP_IDLE : raw;
`endif
  assign {c_addr, c_cs_n, c_r_n, c_w_n, c_rst_n, c_data} = cap;

  hpi_state_e  state;
  logic [AW:0] ptr;
  logic [1:0]  acc_addr;
  logic        inc, err, out_full;
  logic [15:0] mbx_out_q, mem_rdata, rd_mux;
  logic        rst, rd, wr, perr, rel, mem_we;
  assign rst    = reset_reset | ~c_rst_n;
  assign rd     = ~c_cs_n & ~c_r_n & c_w_n;
  assign wr     = ~c_cs_n & c_r_n & ~c_w_n;
  assign perr   = ~c_cs_n & ~c_r_n & ~c_w_n;
  assign rel    = c_cs_n | (c_r_n & c_w_n);
  assign mem_we = state == S_IDLE && wr && c_addr == HPI_REG_DATA;
  assign hpi_int = out_full;
  assign rd_mux = acc_addr == HPI_REG_DATA    ? mem_rdata :
                  acc_addr == HPI_REG_MAILBOX ? mbx_out_q :
                  acc_addr == HPI_REG_ADDRESS ? 16'({ptr}) :
                  {err, 13'b0, out_full, mbx_in_valid};

  hpi_resp_mem #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk(clk_clk),
    .we(mem_we),
    .addr(ptr[AW:1]),
    .wdata(c_data),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      acc_addr     <= HPI_REG_DATA;
      inc          <= 1'b0;
      err          <= 1'b0;
      out_full     <= 1'b0;
      mbx_out_q    <= '0;
      mbx_in_data  <= '0;
      mbx_in_valid <= 1'b0;
      hpi_data_o   <= '0;
      hpi_data_oe  <= 1'b0;
    end else begin
      if (mbx_in_ack) mbx_in_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (perr) begin
            err   <= 1'b1;
            state <= S_WAIT_REL;
          end else if (rd || wr) begin
            acc_addr <= c_addr;
            inc      <= c_addr == HPI_REG_DATA;
            state    <= rd ? S_RD : S_WR;
            if (rd && c_addr == HPI_REG_MAILBOX) out_full <= 1'b0;
            if (wr && c_addr == HPI_REG_MAILBOX) begin
              mbx_in_data  <= c_data;
              mbx_in_valid <= 1'b1;
              if (mbx_in_valid) err <= 1'b1;
            end
            if (wr && c_addr == HPI_REG_ADDRESS) ptr <= {c_data[AW:1], 1'b0};
            if (wr && c_addr == HPI_REG_STATUS && c_data[ST_ERR]) err <= 1'b0;
          end
        end
        S_RD: begin
          hpi_data_o  <= rd_mux;
          hpi_data_oe <= 1'b1;
          state       <= S_RD_DRV;
        end
        S_RD_DRV: state <= S_WAIT_REL;
        S_WR:     state <= S_WAIT_REL;
        S_WAIT_REL: begin
          if (rel) begin
            hpi_data_oe <= 1'b0;
            inc         <= 1'b0;
            state       <= S_IDLE;
            if (inc) ptr <= ptr + (AW+1)'(2);
          end
        end
        default: state <= S_IDLE;
      endcase
      // a device post in the same cycle as a host mailbox read leaves the mailbox full
      if (mbx_out_wr) begin
        mbx_out_q <= mbx_out_data;
        out_full  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: scoreboard bench for hpi_responder host/device mailbox, memory and reset paths
module tb_hpi_responder;
  import hpi_resp_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        cs_n = 1'b1, r_n = 1'b1, w_n = 1'b1, hrst_n = 1'b1;
  logic [15:0] wdata = 16'h0;
  logic [15:0] hpi_data_o, mbx_in_data, mbx_out_data = 16'h0;
  logic        hpi_data_oe, hpi_int, mbx_in_valid, mbx_in_ack = 1'b0, mbx_out_wr = 1'b0;
  logic [15:0] q[$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  hpi_responder dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .hpi_addr_i(addr),
    .hpi_cs_n_i(cs_n),
    .hpi_r_n_i(r_n),
    .hpi_w_n_i(w_n),
    .hpi_rst_n_i(hrst_n),
    .hpi_data_i(wdata),
    .hpi_data_o(hpi_data_o),
    .hpi_data_oe(hpi_data_oe),
    .hpi_int(hpi_int),
    .mbx_in_data(mbx_in_data),
    .mbx_in_valid(mbx_in_valid),
    .mbx_in_ack(mbx_in_ack),
    .mbx_out_data(mbx_out_data),
    .mbx_out_wr(mbx_out_wr)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wdata = d; cs_n = 1'b0; w_n = 1'b0;
    cyc(5);
    cs_n = 1'b1; w_n = 1'b1;
    cyc(4);
  endtask

  task automatic rd_start(input logic [1:0] a, input logic [15:0] e, input string tag);
    q.push_back(e);
    addr = a; cs_n = 1'b0; r_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (hpi_data_oe) break;
    end
    chk({tag, "_oe"}, 16'(hpi_data_oe), 16'h1);
    chk(tag, hpi_data_o, q.pop_front());
  endtask

  task automatic rd_end();
    cs_n = 1'b1; r_n = 1'b1;
    cyc(4);
  endtask

  task automatic host_rd(input logic [1:0] a, input logic [15:0] e, input string tag);
    rd_start(a, e, tag);
    rd_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_oe", 16'(hpi_data_oe), 16'h0);
    chk("rst_int", 16'(hpi_int), 16'h0);
    chk("rst_valid", 16'(mbx_in_valid), 16'h0);
    chk("rst_mbx_in", mbx_in_data, 16'h0);
    chk("rst_data_o", hpi_data_o, 16'h0);
    host_rd(HPI_REG_STATUS, 16'h0000, "rst_status");

    host_wr(HPI_REG_ADDRESS, 16'h0010);
    host_wr(HPI_REG_DATA, 16'hA5A5);
    host_wr(HPI_REG_DATA, 16'h5A5A);
    host_wr(HPI_REG_ADDRESS, 16'h0010);
    host_rd(HPI_REG_DATA, 16'hA5A5, "rd_a5a5");
    host_rd(HPI_REG_DATA, 16'h5A5A, "rd_5a5a");
    host_rd(HPI_REG_ADDRESS, 16'h0014, "ptr_inc");
    host_wr(HPI_REG_ADDRESS, 16'h0011);
    host_rd(HPI_REG_ADDRESS, 16'h0010, "ptr_bit0");

    host_wr(HPI_REG_ADDRESS, 16'h1FFE);
    host_wr(HPI_REG_DATA, 16'h1234);
    host_rd(HPI_REG_ADDRESS, 16'h0000, "ptr_wrap");
    host_wr(HPI_REG_ADDRESS, 16'h1FFE);
    host_rd(HPI_REG_DATA, 16'h1234, "rd_top");

    host_wr(HPI_REG_MAILBOX, 16'hBEEF);
    chk("mbx_in_valid", 16'(mbx_in_valid), 16'h1);
    chk("mbx_in_data", mbx_in_data, 16'hBEEF);
    host_rd(HPI_REG_STATUS, 16'h0001, "st_in_full");
    mbx_in_ack = 1'b1; cyc(1); mbx_in_ack = 1'b0; cyc(1);
    chk("mbx_ack_valid", 16'(mbx_in_valid), 16'h0);
    host_rd(HPI_REG_STATUS, 16'h0000, "st_after_ack");
    host_wr(HPI_REG_MAILBOX, 16'h1111);
    host_wr(HPI_REG_MAILBOX, 16'h2222);
    chk("mbx_overwrite", mbx_in_data, 16'h2222);
    host_rd(HPI_REG_STATUS, 16'h8001, "st_overwrite");
    mbx_in_ack = 1'b1; cyc(1); mbx_in_ack = 1'b0; cyc(1);
    host_wr(HPI_REG_STATUS, 16'h8000);
    host_rd(HPI_REG_STATUS, 16'h0000, "st_w1c_ovf");

    mbx_out_data = 16'hC0DE; mbx_out_wr = 1'b1; cyc(1); mbx_out_wr = 1'b0; cyc(1);
    chk("int_set", 16'(hpi_int), 16'h1);
    host_rd(HPI_REG_STATUS, 16'h0002, "st_out_full");
    rd_start(HPI_REG_MAILBOX, 16'hC0DE, "rd_mbx");
    chk("int_clr", 16'(hpi_int), 16'h0);
    rd_end();
    host_rd(HPI_REG_STATUS, 16'h0000, "st_out_clr");

    host_wr(HPI_REG_ADDRESS, 16'h0010);
    addr = HPI_REG_DATA; wdata = 16'hFFFF; cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0;
    cyc(5);
    cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1;
    cyc(4);
    host_rd(HPI_REG_STATUS, 16'h8000, "st_perr");
    host_rd(HPI_REG_ADDRESS, 16'h0010, "ptr_perr");
    host_rd(HPI_REG_DATA, 16'hA5A5, "mem_perr");
    host_wr(HPI_REG_STATUS, 16'h8000);
    host_rd(HPI_REG_STATUS, 16'h0000, "st_w1c");

    mbx_out_data = 16'h7777; mbx_out_wr = 1'b1; cyc(1); mbx_out_wr = 1'b0; cyc(1);
    host_wr(HPI_REG_ADDRESS, 16'h0010);
    rd_start(HPI_REG_DATA, 16'hA5A5, "rd_pre_srst");
    #1 hrst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!hpi_data_oe) break;
    end
    chk("srst_oe", 16'(hpi_data_oe), 16'h0);
    cs_n = 1'b1; r_n = 1'b1;
    cyc(3);
    hrst_n = 1'b1;
    cyc(4);
    chk("srst_int", 16'(hpi_int), 16'h0);
    host_rd(HPI_REG_ADDRESS, 16'h0000, "srst_ptr");
    host_rd(HPI_REG_STATUS, 16'h0000, "srst_status");
    host_wr(HPI_REG_ADDRESS, 16'h0010);
    host_rd(HPI_REG_DATA, 16'hA5A5, "srst_mem");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- Synthesizable responder for the EZ-OTG-style Host Port Interface (HPI) that the Nios PIO bank drives.
- Sits across from the Nios HPI PIOs (address, cs, r, w, reset, data in/out) and emulates the device side: a local word memory reached through an address pointer, a bidirectional mailbox and a status register.
- Used for on-board loopback bring-up of the HPI software driver with no USB chip fitted, and as a bus-functional target in the Nios-level simulation.

Parameters:
- MEM_WORDS, 4096, depth of the 16-bit local memory; power of two.
- AW, 12, word-address width; equals log2(MEM_WORDS).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- hpi_addr_i  in  2  HPI register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS
- hpi_cs_n_i  in  1  chip select, active low
- hpi_r_n_i  in  1  read strobe, active low
- hpi_w_n_i  in  1  write strobe, active low
- hpi_rst_n_i  in  1  HPI-side soft reset, active low
- hpi_data_i  in  16  write data from the host
- hpi_data_o  out  16  read data to the host
- hpi_data_oe  out  1  high while the responder drives read data
- hpi_int  out  1  interrupt to the host; high while the device-to-host mailbox is full
- mbx_in_data  out  16  last mailbox word written by the host
- mbx_in_valid  out  1  host mailbox word pending
- mbx_in_ack  in  1  device consumes mbx_in_data (single-cycle pulse)
- mbx_out_data  in  16  device-to-host mailbox word
- mbx_out_wr  in  1  device posts mbx_out_data (single-cycle pulse)

Behaviour:
- Clock and reset: single clock domain; reset_reset is synchronous, active-high.
- Reset values: hpi_data_o=0, hpi_data_oe=0, hpi_int=0, mbx_in_data=0, mbx_in_valid=0, address pointer=0, status=0, FSM=IDLE. Memory contents are not cleared.
- Input capture: all HPI inputs pass through a capture stage (see Optional Feature). An access starts at cycle E, the first cycle in which the captured cs_n is 0 and exactly one of r_n and w_n is 0, while the previous captured access state was inactive. hpi_addr and hpi_data are taken from the same captured stage.
- Protocol error: if cs_n=0 with r_n=0 and w_n=0 together, set status[15] (sticky). No other state changes. The FSM goes to WAIT_REL.
- FSM states: IDLE -> RD (E) -> RD_DRV (E+1) -> WAIT_REL; IDLE -> WR (E) -> WAIT_REL; WAIT_REL -> IDLE once the captured cs_n=1, or r_n=1 and w_n=1.
- Read, memory: memory is read at ptr[AW:1] in cycle E.
  - hpi_data_o is registered; hpi_data_oe=1 from E+2 until the cycle after release is detected.
  - hpi_data_o holds its value after oe drops.
- Read, registers:
  - DATA returns mem[ptr>>1].
  - MAILBOX returns mbx_out latch; reading it clears status[1] and hpi_int at E+1.
  - ADDRESS returns ptr.
  - STATUS returns {err, 13'b0, mbx_out_full, mbx_in_full}.
- Write:
  - DATA writes mem[ptr>>1] at E.
  - MAILBOX latches mbx_in_data and sets mbx_in_valid/status[0] at E+1. A write while already full overwrites the data and also sets err.
  - ADDRESS loads ptr with bit0 forced to 0.
  - STATUS: bit15 is write-1-to-clear; other bits are ignored.
- Auto-increment: on release of a DATA access, read or write, ptr += 2 modulo 2*MEM_WORDS (wraps to 0).
- Mailbox local side:
  - mbx_in_ack clears mbx_in_valid next cycle.
  - mbx_out_wr latches data, sets status[1] and asserts hpi_int next cycle.
  - If mbx_out_wr coincides with a host MAILBOX read clear, the set wins.
  - If mbx_in_ack coincides with a host MAILBOX write, the write wins (valid stays 1).
- HPI soft reset: captured hpi_rst_n_i=0 behaves as reset_reset for all registers and the FSM, including mid-access. oe drops the next cycle and memory is retained.

Optional Feature:
- HPI_RESP_SYNC_EN defined: two-flop synchronizer on every HPI input; E is 3 edges after the raw strobe is first sampled low.
- HPI_RESP_SYNC_EN undefined: a single register stage, for the synchronous PIO path; E is 2 edges after.
- All latencies relative to E are unchanged.

Decomposition:
- Package hpi_resp_pkg holds:
  - register-select constants HPI_REG_DATA/MAILBOX/ADDRESS/STATUS;
  - the FSM state enum;
  - status bit indices ST_MBX_IN, ST_MBX_OUT, ST_ERR.
- One sub-module, hpi_resp_mem: single-port 16-bit synchronous RAM, MEM_WORDS deep, one-cycle read latency.

Test Plan:
- Write ADDRESS=0x0010, write DATA 0xA5A5, then 0x5A5A; write ADDRESS=0x0010; two DATA reads -> 0xA5A5, then 0x5A5A; final ADDRESS read = 0x0014.
- ADDRESS=0x1FFE (MEM_WORDS=4096), DATA write 0x1234 -> ADDRESS read returns 0x0000; write ADDRESS=0x1FFE and read DATA -> 0x1234.
- Host writes MAILBOX 0xBEEF -> mbx_in_valid=1, mbx_in_data=0xBEEF, STATUS=0x0001; mbx_in_ack pulse -> STATUS=0x0000.
- Device mbx_out_wr with 0xC0DE -> hpi_int=1, STATUS=0x0002; host MAILBOX read returns 0xC0DE, hpi_int=0 at E+1.
- cs_n=r_n=w_n=0 -> STATUS=0x8000 and memory unchanged; STATUS write 0x8000 -> STATUS=0x0000.
- hpi_rst_n_i low during a read with oe=1 -> oe=0 next cycle, ptr=0, STATUS=0; memory word written earlier still reads back.
